// File: rtl/text_buf_ctrl.sv
// text_buf_ctrl: write-side controller for the VGA text buffer.
// Tracks a (row, col) cursor, turns accepted ASCII codes into registered
// single-port writes, and runs an exclusive full-screen clear sweep.
module text_buf_ctrl #(
  parameter int unsigned COLS  = 71,
  parameter int unsigned ROWS  = 29,
  parameter logic [7:0]  ENTER = 8'ha9,
  parameter logic [7:0]  BKSP  = 8'h08
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ascii_valid,
  input  logic [7:0]  ascii_code,
  output logic        ascii_ready,
  input  logic        clr_req,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [ADDR_W-1:0]   cur_addr;

  // Linear address of the cursor cell; backspace target is simply one less.
  assign cur_addr = ADDR_W'(ADDR_W'(row_q) * ADDR_W'(COLS)) + ADDR_W'(col_q);

  // Only combinational output: accept when idle and no clear is pending.
  assign ascii_ready = (state_q == IDLE) && !clr_req && !rst;

  // State register and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      sweep_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      sweep_q   <= sweep_d;
    end
  end

  // Next-state, cursor update and write generation.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    sweep_d   = sweep_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (clr_req) begin
          // Clear wins over a simultaneous code; first cell written next cycle.
          state_d   = CLEAR;
          busy_d    = 1'b1;
          sweep_d   = '0;
          row_d     = '0;
          col_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
        end else if (ascii_valid && ascii_ready) begin
          if (ascii_code == 8'h00) begin
            // Null code: ignored.
          end else if (ascii_code == ENTER) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
          end else if (ascii_code == BKSP) begin
            if ((row_q != '0) || (col_q != '0)) begin
              if (col_q != '0) begin
                col_d = col_q - COL_W'(1);
              end else begin
                row_d = row_q - ROW_W'(1);
                col_d = LAST_COL;
              end
              wr_en_d   = 1'b1;
              wr_addr_d = cur_addr - ADDR_W'(1);
              wr_data_d = '0;
            end
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = ascii_code;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end

      CLEAR: begin
        // sweep_q holds the address currently on the write port.
        if (sweep_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          sweep_d = '0;
        end else begin
          sweep_d   = sweep_q + ADDR_W'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = sweep_q + ADDR_W'(1);
          wr_data_d = '0;
          busy_d    = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_buf_ctrl.sv
// tb_text_buf_ctrl: directed self-checking bench for text_buf_ctrl.
module tb_text_buf_ctrl;

  localparam int unsigned COLS  = 71;
  localparam int unsigned ROWS  = 29;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam logic [7:0]  ENTER = 8'ha9;
  localparam logic [7:0]  BKSP  = 8'h08;

  logic        clk;
  logic        rst;
  logic        ascii_valid;
  logic [7:0]  ascii_code;
  logic        ascii_ready;
  logic        clr_req;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int checks = 0;
  int errors = 0;

  text_buf_ctrl #(
    .COLS (COLS),
    .ROWS (ROWS),
    .ENTER(ENTER),
    .BKSP (BKSP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ascii_valid(ascii_valid),
    .ascii_code (ascii_code),
    .ascii_ready(ascii_ready),
    .clr_req    (clr_req),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ascii_valid = 1'b0;
    clr_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic send(input logic [7:0] code);
    ascii_valid = 1'b1;
    ascii_code  = code;
    tick();
    ascii_valid = 1'b0;
    ascii_code  = 8'h00;
  endtask

  task automatic chk_cur(input string tag, input int r, input int c);
    chk({tag, ".row"}, 32'(cursor_row), 32'(r));
    chk({tag, ".col"}, 32'(cursor_col), 32'(c));
  endtask

  task automatic chk_wr(input string tag, input logic en, input int addr, input logic [7:0] data);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(en));
    if (en) begin
      chk({tag, ".addr"}, 32'(wr_addr), 32'(addr));
      chk({tag, ".data"}, 32'(wr_data), 32'(data));
    end
  endtask

  // Runs a clear from the current cursor; aborts with reset at abort_at if < CELLS.
  task automatic run_clear(input int abort_at);
    clr_req     = 1'b1;
    ascii_valid = 1'b1;
    ascii_code  = 8'h55;
    #1;
    chk("clr.ready_blocked", 32'(ascii_ready), 32'd0);
    tick();
    clr_req     = 1'b0;
    ascii_valid = 1'b0;
    for (int k = 0; k < int'(CELLS); k++) begin
      if (k == abort_at) begin
        chk("abort.addr", 32'(wr_addr), 32'(k));
        rst = 1'b1;
        tick();
        chk_wr("abort", 1'b0, 0, 8'h00);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.ready_in_rst", 32'(ascii_ready), 32'd0);
        chk_cur("abort", 0, 0);
        rst = 1'b0;
        #1;
        chk("abort.ready", 32'(ascii_ready), 32'd1);
        return;
      end
      chk("sweep.wr_en", 32'(wr_en), 32'd1);
      chk("sweep.addr", 32'(wr_addr), 32'(k));
      chk("sweep.data", 32'(wr_data), 32'd0);
      chk("sweep.busy", 32'(busy), 32'd1);
      chk("sweep.ready", 32'(ascii_ready), 32'd0);
      if (k == 0) chk_cur("sweep.start", 0, 0);
      // A mid-sweep request must not restart the sweep.
      clr_req = (k == 500);
      tick();
    end
    clr_req = 1'b0;
    #1;
    chk_wr("clr.done", 1'b0, 0, 8'h00);
    chk("clr.done.busy", 32'(busy), 32'd0);
    chk("clr.done.ready", 32'(ascii_ready), 32'd1);
    chk_cur("clr.done", 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    ascii_valid = 1'b0;
    ascii_code = 8'h00;
    clr_req = 1'b0;
    tick();
    tick();
    // Reset state, sampled while reset is still held.
    chk("rst.wr_en", 32'(wr_en), 32'd0);
    chk("rst.addr", 32'(wr_addr), 32'd0);
    chk("rst.data", 32'(wr_data), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ready", 32'(ascii_ready), 32'd0);
    chk_cur("rst", 0, 0);
    rst = 1'b0;
    #1;
    chk("rst.ready_after", 32'(ascii_ready), 32'd1);

    // Single printable character.
    send(8'h41);
    chk_wr("A", 1'b1, 0, 8'h41);
    chk_cur("A", 0, 1);
    tick();
    chk("A.one_cycle", 32'(wr_en), 32'd0);

    // Full row back-to-back, wrap to next row.
    do_reset();
    for (int i = 0; i < int'(COLS); i++) begin
      send(8'h30);
      chk_wr("row0", 1'b1, i, 8'h30);
    end
    chk_cur("row0.end", 1, 0);
    send(8'h42);
    chk_wr("B", 1'b1, 71, 8'h42);
    chk_cur("B", 1, 1);

    // Enter then backspace across a row boundary.
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h61);
    chk_cur("pre_enter", 0, 5);
    send(ENTER);
    chk_wr("enter", 1'b0, 0, 8'h00);
    chk_cur("enter", 1, 0);
    send(BKSP);
    chk_wr("bksp", 1'b1, 70, 8'h00);
    chk_cur("bksp", 0, 70);
    send(BKSP);
    chk_wr("bksp2", 1'b1, 69, 8'h00);
    chk_cur("bksp2", 0, 69);

    // Backspace at origin and null code do nothing.
    do_reset();
    send(BKSP);
    chk_wr("bksp00", 1'b0, 0, 8'h00);
    chk_cur("bksp00", 0, 0);
    send(8'h00);
    chk_wr("null", 1'b0, 0, 8'h00);
    chk_cur("null", 0, 0);

    // Last cell wraps to origin; Enter on the last row wraps too.
    do_reset();
    for (int i = 0; i < int'(ROWS) - 1; i++) send(ENTER);
    chk_cur("row28", 28, 0);
    for (int i = 0; i < int'(COLS) - 1; i++) send(8'h2e);
    chk_cur("lastcell", 28, 70);
    send(8'h5a);
    chk_wr("Z", 1'b1, 2058, 8'h5a);
    chk_cur("Z", 0, 0);
    for (int i = 0; i < int'(ROWS) - 1; i++) send(ENTER);
    for (int i = 0; i < 3; i++) send(8'h2e);
    chk_cur("pre_wrap_enter", 28, 3);
    send(ENTER);
    chk_wr("wrap_enter", 1'b0, 0, 8'h00);
    chk_cur("wrap_enter", 0, 0);

    // Full clear from a non-origin cursor; simultaneous code is dropped.
    for (int i = 0; i < 3; i++) send(8'h2e);
    chk_cur("pre_clr", 0, 3);
    run_clear(int'(CELLS));
    send(8'h43);
    chk_wr("post_clr", 1'b1, 0, 8'h43);

    // Reset in the middle of a sweep.
    run_clear(1000);
    send(8'h44);
    chk_wr("post_abort", 1'b1, 0, 8'h44);
    chk_cur("post_abort", 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
